// File: rtl/sim_harness_ctrl.sv
// Run controller for CPU simulation / bring-up: sequences CPU reset, counts run
// cycles, and ends the run on an exit-mailbox write, a cycle timeout or a fetch hang.
module sim_harness_ctrl #(
  parameter int unsigned           ADDR_WIDTH   = 16,
  parameter int unsigned           DATA_WIDTH   = 16,
  parameter int unsigned           CNT_WIDTH    = 32,
  parameter int unsigned           RESET_CYCLES = 2,
  parameter int unsigned           MAX_CYCLES   = 20,
  parameter int unsigned           HANG_CYCLES  = 8,
  parameter logic [ADDR_WIDTH-1:0] EXIT_ADDR    = 'hFFFE,
  parameter logic [ADDR_WIDTH-1:0] CONSOLE_ADDR = 'hFFFC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] iaddr,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  output logic                  cpu_rst,
  output logic                  running,
  output logic                  done,
  output logic [2:0]            status,
  output logic [DATA_WIDTH-1:0] exit_code,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic                  con_valid,
  output logic [7:0]            con_data
);

  localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0]     RST_LAST   = RST_W'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(MAX_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HANG_LIM   = CNT_WIDTH'(HANG_CYCLES);
  localparam bit                   TIMEOUT_EN = (MAX_CYCLES != 0);
  localparam bit                   HANG_EN    = (HANG_CYCLES != 0);

  localparam logic [2:0] ST_NONE    = 3'd0;
  localparam logic [2:0] ST_PASS    = 3'd1;
  localparam logic [2:0] ST_FAIL    = 3'd2;
  localparam logic [2:0] ST_TIMEOUT = 3'd3;
  localparam logic [2:0] ST_HANG    = 3'd4;

  typedef enum logic [2:0] {
    S_RESET,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT,
    S_HANG
  } state_t;

  state_t                  state_q, state_d;
  logic [RST_W-1:0]        rst_cnt_q, rst_cnt_d;
  logic [CNT_WIDTH-1:0]    same_cnt_q, same_cnt_d;
  logic [ADDR_WIDTH-1:0]   prev_iaddr_q;
  logic                    prev_valid_q, prev_valid_d;

  logic                    cpu_rst_d, running_d, done_d, con_valid_d;
  logic [2:0]              status_d;
  logic [DATA_WIDTH-1:0]   exit_code_d;
  logic [CNT_WIDTH-1:0]    cycle_count_d;
  logic [7:0]              con_data_d;

  logic                    exit_hit, con_hit, iaddr_match, hang_hit, timeout_hit, finish;
  logic [CNT_WIDTH-1:0]    same_inc;

  assign exit_hit    = we && (waddr == EXIT_ADDR);
  assign con_hit     = we && (waddr == CONSOLE_ADDR);
  assign iaddr_match = prev_valid_q && (iaddr == prev_iaddr_q);
  assign same_inc    = same_cnt_q + CNT_WIDTH'(1);
  assign hang_hit    = HANG_EN && iaddr_match && (same_inc == HANG_LIM);
  assign timeout_hit = TIMEOUT_EN && (cycle_count == CNT_LAST);

  // Next-state and next-output logic; terminal states hold everything.
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    same_cnt_d    = same_cnt_q;
    prev_valid_d  = prev_valid_q;
    cpu_rst_d     = cpu_rst;
    running_d     = running;
    done_d        = done;
    status_d      = status;
    exit_code_d   = exit_code;
    cycle_count_d = cycle_count;
    con_valid_d   = 1'b0;
    con_data_d    = con_data;
    finish        = 1'b0;

    case (state_q)
      S_RESET: begin
        rst_cnt_d = rst_cnt_q + RST_W'(1);
        if (rst_cnt_q == RST_LAST) begin
          state_d   = S_RUN;
          cpu_rst_d = 1'b0;
          running_d = 1'b1;
        end
      end
      S_RUN: begin
        cycle_count_d = cycle_count + CNT_WIDTH'(1);
        prev_valid_d  = 1'b1;
        same_cnt_d    = iaddr_match ? same_inc : '0;
        if (con_hit) begin
          con_valid_d = 1'b1;
          con_data_d  = wdata[7:0];
        end
        // Exit mailbox outranks hang, which outranks timeout.
        if (exit_hit) begin
          exit_code_d = wdata;
          finish      = 1'b1;
          if (wdata == '0) begin
            state_d  = S_PASS;
            status_d = ST_PASS;
          end else begin
            state_d  = S_FAIL;
            status_d = ST_FAIL;
          end
        end else if (hang_hit) begin
          finish   = 1'b1;
          state_d  = S_HANG;
          status_d = ST_HANG;
        end else if (timeout_hit) begin
          finish   = 1'b1;
          state_d  = S_TIMEOUT;
          status_d = ST_TIMEOUT;
        end
      end
      default: ;
    endcase

    if (finish) begin
      done_d    = 1'b1;
      running_d = 1'b0;
      cpu_rst_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RESET;
      rst_cnt_q    <= '0;
      same_cnt_q   <= '0;
      prev_valid_q <= 1'b0;
      prev_iaddr_q <= '0;
      cpu_rst      <= 1'b1;
      running      <= 1'b0;
      done         <= 1'b0;
      status       <= ST_NONE;
      exit_code    <= '0;
      cycle_count  <= '0;
      con_valid    <= 1'b0;
      con_data     <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      same_cnt_q   <= same_cnt_d;
      prev_valid_q <= prev_valid_d;
      prev_iaddr_q <= iaddr;
      cpu_rst      <= cpu_rst_d;
      running      <= running_d;
      done         <= done_d;
      status       <= status_d;
      exit_code    <= exit_code_d;
      cycle_count  <= cycle_count_d;
      con_valid    <= con_valid_d;
      con_data     <= con_data_d;
    end
  end

endmodule
